vga_disp_update_ctrl: RTL and testbench

//   Frame-synchronous update controller for the VGA glyph display. Game logic writes
//   new main/player values through a valid/ready port. Writes are staged in shadow

---
 rtl/vga_disp_update_ctrl_pkg.sv | 29 ++
 rtl/vga_disp_update_ctrl_frame_tick.sv | 44 ++++
 rtl/vga_disp_update_ctrl.sv | 106 ++++++++++
 tb/tb_vga_disp_update_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_disp_update_ctrl_pkg.sv
// Shared constants for the VGA glyph display: slot indices, update FSM states
// and the 640x480@60 timing numbers also used by the timing generator.
package vga_disp_update_ctrl_pkg;

    localparam int SLOT_MAIN = 0;
    localparam int SLOT_P1   = 1;
    localparam int SLOT_P2   = 2;
    localparam int SLOT_P3   = 3;
    localparam int SLOT_P4   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int HS_VISIBLE = 640;
    localparam int HS_FRONT   = 16;
    localparam int HS_SYNC    = 96;
    localparam int HS_BACK    = 48;
    localparam int HS_TOTAL   = HS_VISIBLE + HS_FRONT + HS_SYNC + HS_BACK;

    localparam int VS_VISIBLE = 480;
    localparam int VS_FRONT   = 10;
    localparam int VS_SYNC    = 2;
    localparam int VS_BACK    = 33;
    localparam int VS_TOTAL   = VS_VISIBLE + VS_FRONT + VS_SYNC + VS_BACK;

endpackage

// File: rtl/vga_disp_update_ctrl_frame_tick.sv
// Vertical-blank edge detector plus frame counter and blink strobe.
// vb_edge is combinational from vcount; frame_cnt/blink update one clk after it.
module vga_frame_tick #(
    parameter logic [9:0] VS_INIT      = 10'd480,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  vcount,
    output logic        vb_edge,
    output logic [15:0] frame_cnt,
    output logic        blink
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [9:0]    vcount_q;
    logic [BW-1:0] blink_cnt;

    // vcount_q resets to all-ones so a vcount already at VS_INIT still fires once
    assign vb_edge = (vcount == VS_INIT) && (vcount_q != VS_INIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcount_q  <= 10'h3FF;
            frame_cnt <= 16'd0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            vcount_q <= vcount;
            if (vb_edge) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_disp_update_ctrl.sv
// Stages main/player writes in shadow registers and commits them at vblank start.
// Outputs update 2 clk after vb_edge; wr_ready drops in the edge and COMMIT cycles.
module vga_disp_update_ctrl
    import vga_disp_update_ctrl_pkg::*;
#(
    parameter logic [9:0] VS_INIT      = 10'd480,
    parameter int         BLINK_FRAMES = 30,
    parameter int         NUM_SLOTS    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  vcount,
    input  logic        wr_valid,
    input  logic [2:0]  wr_sel,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic [7:0]  value,
    output logic [15:0] p1,
    output logic [15:0] p2,
    output logic [15:0] p3,
    output logic [15:0] p4,
    output logic        pending,
    output logic        commit_pulse,
    output logic [15:0] frame_cnt,
    output logic        blink,
    output logic        err_sel
);

    localparam logic [2:0] SLOT_LIMIT = 3'(NUM_SLOTS);

    state_t                 state, state_nxt;
    logic                   run_q;
    logic                   vb_edge;
    logic                   accept, legal;
    logic [15:0]            shadow [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   dirty, dirty_nxt;

    vga_frame_tick #(
        .VS_INIT      (VS_INIT),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .vcount    (vcount),
        .vb_edge   (vb_edge),
        .frame_cnt (frame_cnt),
        .blink     (blink)
    );

    // Blocking writes on the edge cycle keeps a write from straddling a commit
    assign wr_ready = run_q && (state != COMMIT) && !vb_edge;
    assign accept   = wr_valid && wr_ready;
    assign legal    = (wr_sel < SLOT_LIMIT);

    always_comb begin
        state_nxt = state;
        dirty_nxt = dirty;
        if (state == COMMIT) begin
            dirty_nxt = '0;
        end
        if (accept && legal) begin
            dirty_nxt[wr_sel] = 1'b1;
        end
        case (state)
            IDLE:    if (accept && legal) state_nxt = ARMED;
            ARMED:   if (vb_edge)         state_nxt = COMMIT;
            COMMIT:                       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            run_q        <= 1'b0;
            dirty        <= '0;
            pending      <= 1'b0;
            commit_pulse <= 1'b0;
            err_sel      <= 1'b0;
            value        <= 8'd0;
            p1           <= 16'd0;
            p2           <= 16'd0;
            p3           <= 16'd0;
            p4           <= 16'd0;
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= 16'd0;
        end else begin
            state        <= state_nxt;
            run_q        <= 1'b1;
            dirty        <= dirty_nxt;
            pending      <= |dirty_nxt;
            commit_pulse <= (state == COMMIT);
            if (accept) begin
                if (legal) shadow[wr_sel] <= wr_data;
                else       err_sel        <= 1'b1;
            end
            if (state == COMMIT) begin
                if (dirty[SLOT_MAIN]) value <= shadow[SLOT_MAIN][7:0];
                if (dirty[SLOT_P1])   p1    <= shadow[SLOT_P1];
                if (dirty[SLOT_P2])   p2    <= shadow[SLOT_P2];
                if (dirty[SLOT_P3])   p3    <= shadow[SLOT_P3];
                if (dirty[SLOT_P4])   p4    <= shadow[SLOT_P4];
            end
        end
    end

endmodule

// File: tb/tb_vga_disp_update_ctrl.sv
// Directed bench for vga_disp_update_ctrl: inputs change and outputs are sampled on negedge.
module tb_vga_disp_update_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  vcount = 10'd0;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_sel = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_ready, pending, commit_pulse, blink, err_sel;
    logic [7:0]  value;
    logic [15:0] p1, p2, p3, p4, frame_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    vga_disp_update_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .vcount       (vcount),
        .wr_valid     (wr_valid),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .value        (value),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .p4           (p4),
        .pending      (pending),
        .commit_pulse (commit_pulse),
        .frame_cnt    (frame_cnt),
        .blink        (blink),
        .err_sel      (err_sel)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns on the negedge after the handshake with wr_valid dropped
    task automatic do_write(input logic [2:0] sel, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_sel = sel; wr_data = d;
        #1;
        while (!wr_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({31'd0, wr_ready}, 32'd1, "wr_handshake_timeout");
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // One vertical blank: vcount sits at 480 for 4 clk; counts commit pulses seen
    task automatic vblank();
        @(negedge clk);
        vcount = 10'd480;
        repeat (4) begin
            @(negedge clk);
            if (commit_pulse) pulses++;
        end
        vcount = 10'd100;
        @(negedge clk);
        if (commit_pulse) pulses++;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk({31'd0, wr_ready}, 32'd0, "rst_wr_ready");
        chk({24'd0, value}, 32'd0, "rst_value");
        chk({16'd0, frame_cnt}, 32'd0, "rst_frame_cnt");
        @(negedge clk);
        rst = 1'b1;
        vcount = 10'd100;
        @(negedge clk); @(negedge clk);
        chk({31'd0, wr_ready}, 32'd1, "post_rst_wr_ready");
        chk({31'd0, pending}, 32'd0, "post_rst_pending");

        // 60 idle frames: blink toggles at 30 and 60, no commits
        pulses = 0;
        for (int f = 1; f <= 60; f++) begin
            vblank();
            if (f == 29) chk({31'd0, blink}, 32'd0, "blink_f29");
            if (f == 30) chk({31'd0, blink}, 32'd1, "blink_f30");
            if (f == 59) chk({31'd0, blink}, 32'd1, "blink_f59");
        end
        chk({16'd0, frame_cnt}, 32'd60, "frame_cnt_60");
        chk({31'd0, blink}, 32'd0, "blink_f60");
        chk(pulses, 32'd0, "idle_no_commit");

        // main write: held until vblank, lands 2 clk after the edge
        do_write(3'd0, 16'h00A5);
        chk({24'd0, value}, 32'd0, "t1_value_before");
        chk({31'd0, pending}, 32'd1, "t1_pending");
        vcount = 10'd480;
        #1;
        chk({31'd0, wr_ready}, 32'd0, "t1_ready_edge");
        @(negedge clk);
        chk({24'd0, value}, 32'd0, "t1_value_commit_cyc");
        chk({31'd0, commit_pulse}, 32'd0, "t1_pulse_early");
        chk({31'd0, wr_ready}, 32'd0, "t1_ready_commit");
        @(negedge clk);
        chk({24'd0, value}, 32'hA5, "t1_value_after");
        chk({31'd0, commit_pulse}, 32'd1, "t1_pulse");
        chk({31'd0, pending}, 32'd0, "t1_pending_clr");
        chk({16'd0, frame_cnt}, 32'd61, "t1_frame_cnt");
        @(negedge clk);
        chk({31'd0, commit_pulse}, 32'd0, "t1_pulse_one_clk");
        vcount = 10'd100;

        // last write to a slot wins, others untouched
        do_write(3'd2, 16'h1234);
        do_write(3'd2, 16'hBEEF);
        vblank();
        chk({16'd0, p2}, 32'hBEEF, "t2_p2");
        chk({16'd0, p1}, 32'd0, "t2_p1");
        chk({16'd0, p3}, 32'd0, "t2_p3");
        chk({16'd0, p4}, 32'd0, "t2_p4");
        chk({24'd0, value}, 32'hA5, "t2_value");

        // write held across the edge waits out the commit
        do_write(3'd1, 16'h1111);
        @(negedge clk);
        wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'hCAFE;
        vcount = 10'd480;
        #1;
        chk({31'd0, wr_ready}, 32'd0, "t3_ready_edge");
        @(negedge clk); #1;
        chk({31'd0, wr_ready}, 32'd0, "t3_ready_commit");
        @(negedge clk); #1;
        chk({31'd0, wr_ready}, 32'd1, "t3_ready_back");
        chk({16'd0, p1}, 32'h1111, "t3_p1");
        chk({31'd0, pending}, 32'd0, "t3_pending_at_commit");
        @(negedge clk);
        wr_valid = 1'b0;
        chk({31'd0, pending}, 32'd1, "t3_pending_after");
        chk({16'd0, p3}, 32'd0, "t3_p3_not_yet");
        vcount = 10'd100;
        vblank();
        chk({16'd0, p3}, 32'hCAFE, "t3_p3");
        chk({31'd0, pending}, 32'd0, "t3_pending_clr");

        // illegal select: handshake, sticky error, no staging
        pulses = 0;
        do_write(3'd6, 16'hDEAD);
        chk({31'd0, err_sel}, 32'd1, "t4_err_sel");
        chk({31'd0, pending}, 32'd0, "t4_pending");
        vblank();
        chk(pulses, 32'd0, "t4_no_commit");
        chk({24'd0, value}, 32'hA5, "t4_value");
        chk({16'd0, p1}, 32'h1111, "t4_p1");
        chk({16'd0, p2}, 32'hBEEF, "t4_p2");
        chk({16'd0, p3}, 32'hCAFE, "t4_p3");
        chk({16'd0, p4}, 32'd0, "t4_p4");

        // reset while armed discards the staged write
        do_write(3'd4, 16'h4444);
        chk({31'd0, pending}, 32'd1, "t6_pending");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({24'd0, value}, 32'd0, "t6_value");
        chk({16'd0, p2}, 32'd0, "t6_p2");
        chk({31'd0, err_sel}, 32'd0, "t6_err_sel");
        chk({31'd0, pending}, 32'd0, "t6_pending_rst");
        chk({16'd0, frame_cnt}, 32'd0, "t6_frame_cnt");
        chk({31'd0, wr_ready}, 32'd0, "t6_wr_ready");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulses = 0;
        vblank();
        chk(pulses, 32'd0, "t6_no_commit");
        chk({16'd0, p4}, 32'd0, "t6_p4");
        chk({16'd0, frame_cnt}, 32'd1, "t6_frame_cnt_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
